ps2_device_tx: RTL and testbench

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_device_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_device_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-to-host byte transmitter with a small transmit FIFO.
// Each queued byte is sent as an 11-bit frame (start, 8 data LSB first, odd
// parity, stop) on open-drain clock/data lines, followed by an idle gap.
// Optional build macro: PS2_INHIBIT_DETECT_EN enables host-inhibit handling
// (no frame start while the clock line is held low; abort and retransmit if
// the host pulls the clock low during a HIGH phase).
module ps2_device_tx #(
    parameter int DEPTH       = 8,
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data,
    input  logic                   rts,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   ps2_clk_oe,
    output logic                   ps2_data_oe,
    input  logic                   ps2_clk_in
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic [10:0]   frame;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    bit_idx;
    logic [3:0]    bit_next;
    logic          line_ok;

`ifdef PS2_INHIBIT_DETECT_EN
    assign line_ok = ps2_clk_in;
`else
    logic unused_clk_in;
    assign unused_clk_in = ps2_clk_in;
    assign line_ok       = 1'b1;
`endif

    // FIFO status: the extra pointer bit distinguishes full from empty.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign push  = rts && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    // The head byte stays put for the whole frame; pushes only touch the tail.
    assign frame = {1'b1, ~^head, head, 1'b0};

    // FIFO pointers and sticky overflow flag.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (rts && full)
                overflow <= 1'b1;
        end
    end

    // FIFO storage write.
    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= data;
    end

    // Frame FSM state, phase counter and bit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
        end
    end

    // Frame FSM next-state logic and FIFO pop request.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (level != '0 && line_ok) begin
                    state_next = HIGH;
                    bit_next   = 4'd0;
                end
            end
            HIGH: begin
                if (cnt == CW'(HALF_PERIOD - 1)) begin
                    cnt_next   = '0;
                    // A host holding the clock low at the end of HIGH aborts
                    // the frame; the byte stays queued for a full resend.
                    state_next = line_ok ? LOW : GAP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            LOW: begin
                if (cnt == CW'(HALF_PERIOD - 1)) begin
                    cnt_next = '0;
                    if (bit_idx == 4'd10) begin
                        pop        = 1'b1;
                        state_next = GAP;
                    end else begin
                        bit_next   = bit_idx + 4'd1;
                        state_next = HIGH;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Line drivers: data bit is presented for both halves of each bit period.
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = (state == LOW);
    assign ps2_data_oe = ((state == HIGH) || (state == LOW)) && !frame[bit_idx];

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: scoreboard bench for ps2_device_tx. Accepted bytes are
// queued by the stimulus; a monitor decodes frames off the line outputs and
// compares them with frames built from the byte by plain arithmetic.
module tb_ps2_device_tx;

    localparam int DEPTH        = 4;
    localparam int HALF_PERIOD  = 4;
    localparam int GAP_CYCLES   = 8;
    localparam int FRAME_CYCLES = 22 * HALF_PERIOD;
`ifdef PS2_INHIBIT_DETECT_EN
    localparam bit INH = 1'b1;
`else
    localparam bit INH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       rts = 1'b0;
    logic       full;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       ps2_clk_in = 1'b1;

    ps2_device_tx #(
        .DEPTH      (DEPTH),
        .HALF_PERIOD(HALF_PERIOD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .rts        (rts),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .busy       (busy),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .ps2_clk_in (ps2_clk_in)
    );

    always #5 clk = ~clk;

    int          tests  = 0;
    int          fails  = 0;
    int          aborts = 0;
    int          frames = 0;
    byte unsigned exp_q[$];
    logic        ovf_m = 1'b0;
    logic [10:0] last_seq = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels (1 = released/high) for one frame, bit 0 first.
    function automatic logic [10:0] line_bits(input byte unsigned b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[k+1] = b[k];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Called on a falling edge; the push lands on the following rising edge.
    task automatic push(input logic [7:0] b);
        rts  = 1'b1;
        data = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovf_m = 1'b1;
        @(negedge clk);
        rts = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_start", busy, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", (exp_q.size() == 0) && !busy, 1'b1);
    endtask

    // Monitor: decode frames and keep level/full/overflow against the model.
    logic        in_frame = 1'b0;
    logic        have_prev = 1'b0;
    logic        pb = 1'b0;
    logic        pc = 1'b0;
    int          nb = 0;
    int          cyc = 0;
    int          gapc = 0;
    logic [10:0] seq = '0;
    logic [10:0] line;
    byte unsigned mb;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
                gapc      = 0;
                pb        = 1'b0;
                pc        = 1'b0;
            end else begin
                if (!in_frame && busy && !pb) begin
                    if (have_prev) check("gap_len", gapc >= GAP_CYCLES, 1'b1);
                    in_frame = 1'b1;
                    nb       = 0;
                    cyc      = 0;
                    seq      = '0;
                end
                if (in_frame) begin
                    if (ps2_clk_oe && !pc && nb < 11) begin
                        seq[nb] = ps2_data_oe;
                        nb++;
                    end
                    if (!ps2_clk_oe && pc && nb == 11) begin
                        line = ~seq;
                        if (exp_q.size() == 0) begin
                            check("frame_expected", 1'b0, 1'b1);
                        end else begin
                            mb = exp_q.pop_front();
                            check("frame_bits", line, line_bits(mb));
                        end
                        check("frame_len", cyc, FRAME_CYCLES);
                        last_seq  = seq;
                        frames++;
                        in_frame  = 1'b0;
                        have_prev = 1'b1;
                    end else if (!busy) begin
                        aborts++;
                        in_frame  = 1'b0;
                        have_prev = 1'b1;
                    end else begin
                        cyc++;
                    end
                end
                if (!ps2_clk_oe && !ps2_data_oe) gapc++;
                else gapc = 0;
                pb = busy;
                pc = ps2_clk_oe;
            end
            check("level", level, exp_q.size());
            check("full", full, exp_q.size() == DEPTH);
            check("overflow", overflow, ovf_m);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] b0, b1, b2, bx;
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        rst = 1'b0;

        // Single byte 0x0B: exact line sequence, pop at stop end, gap tail.
        push(8'h0B);
        check("level_after_push", level, 1);
        n = 0;
        while (level != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pop_seen", level, 0);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_tail", n, GAP_CYCLES);
        check("seq_0x0B", last_seq, 11'b01111101001);

        // 0x00: parity bit is 1, so the data line is released during bit 9.
        push(8'h00);
        wait_drain();
        check("parity_0x00", last_seq[9], 1'b0);

        // Five back-to-back pushes while idle: four kept, fifth dropped.
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
        check("burst_full", full, 1'b1);
        check("burst_overflow", overflow, 1'b1);
        check("burst_level", level, DEPTH);
        wait_drain();

        // Push landing on the same edge as the pop keeps level unchanged.
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        bx = 8'($urandom_range(0, 255));
        push(b0);
        wait_busy();
        push(b1);
        push(b2);
        repeat (FRAME_CYCLES - 3) @(negedge clk);
        check("level_before_pop", level, 3);
        push(bx);
        check("level_push_pop", level, 3);
        wait_drain();

        // Host pulls the clock low during the HIGH phase of bit 4.
        push(8'($urandom_range(0, 255)));
        wait_busy();
        repeat (8 * 4) @(negedge clk);
        ps2_clk_in = 1'b0;
        repeat (HALF_PERIOD) @(negedge clk);
        ps2_clk_in = 1'b1;
        check("inhibit_clk_oe", ps2_clk_oe, !INH);
        check("inhibit_level", level, 1);
        wait_drain();
        check("abort_count", aborts, INH ? 1 : 0);

        // Randomised pushes with random spacing, occasionally overrunning.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            push(8'($urandom_range(0, 255)));
        end
        wait_drain();

        // Reset during bit 6 of a frame with three bytes queued.
        check("ovf_before_rst", overflow, 1'b1);
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        repeat (8 * 6 + 1) @(negedge clk);
        check("level_before_rst", level, 3);
        rst = 1'b1;
        exp_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after reset.
        n = frames;
        push(8'hA5);
        wait_drain();
        check("post_rst_frame", frames - n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
